// File: rtl/fcl_mac_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fcl_pkg                                                   |
// | Purpose  : Shared constants, types and FSM encoding for the FC-layer |
// |            MAC sequencer (fcl_mac_seq) and its helpers.              |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fcl_pkg;

  localparam int OPERAND_WIDTH = 8;
  localparam int MAC_WIDTH     = 2*OPERAND_WIDTH + 1;
  localparam int ACC_WIDTH     = 24;
  localparam int MAX_INPUTS    = 400;
  localparam int ADDR_WIDTH    = $clog2((MAX_INPUTS + 1) / 2);
  localparam int LEN_WIDTH     = $clog2(MAX_INPUTS + 1);

  typedef logic [OPERAND_WIDTH-1:0] operand_t;
  typedef logic [ACC_WIDTH-1:0]     acc_t;
  typedef operand_t [1:0]           pair_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_HOLD  = 3'd4
  } fcl_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/fcl_mac_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fcl_mac_seq_if                                            |
// | Purpose  : Bundles the controller, buffer, MAC and result signals of |
// |            the FC-layer MAC sequencer.                               |
// | Modports : master - the sequencer (drives *_o)                       |
// |            slave  - the surrounding layer logic (drives *_i)         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface fcl_mac_seq_if;
  import fcl_pkg::*;

  logic                  start_i;
  logic [LEN_WIDTH-1:0]  in_len_i;
  acc_t                  bias_i;
  logic                  busy_o;
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  pair_t                 act_rd_data_i;  // [0] = element 2k, [1] = element 2k+1
  pair_t                 wgt_rd_data_i;
  pair_t                 mac_pair_a_o;   // [1] = weight, [0] = activation
  pair_t                 mac_pair_b_o;
  logic [MAC_WIDTH-1:0]  mac_sum_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  acc_t                  res_data_o;
  logic                  res_sat_o;

  modport master (
    input  start_i, in_len_i, bias_i, act_rd_data_i, wgt_rd_data_i,
           mac_sum_i, res_ready_i,
    output busy_o, rd_en_o, rd_addr_o, mac_pair_a_o, mac_pair_b_o,
           res_valid_o, res_data_o, res_sat_o
  );

  modport slave (
    output start_i, in_len_i, bias_i, act_rd_data_i, wgt_rd_data_i,
           mac_sum_i, res_ready_i,
    input  busy_o, rd_en_o, rd_addr_o, mac_pair_a_o, mac_pair_b_o,
           res_valid_o, res_data_o, res_sat_o
  );

endinterface
`default_nettype wire

// File: rtl/fcl_mac_seq_sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fcl_sat_add                                               |
// | Purpose  : Unsigned ACC_WIDTH adder that clamps to all-ones on carry |
// |            out and flags the overflow.                               |
// | Ports    : a, b  - addends                                           |
// |            sum   - saturated sum                                     |
// |            ovf   - high when the true sum exceeded the range         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fcl_sat_add
  import fcl_pkg::*;
(
  input  acc_t a,
  input  acc_t b,
  output acc_t sum,
  output logic ovf
);

  logic [ACC_WIDTH:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b};
  assign ovf    = w_full[ACC_WIDTH];
  assign sum    = ovf ? '1 : w_full[ACC_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/fcl_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fcl_mac_seq                                               |
// | Purpose  : Streams activation/weight pairs into the two-lane MAC,    |
// |            accumulates the MAC sums of one neuron, adds the bias and |
// |            hands back a saturated result over valid/ready.           |
// | Ports    : fcl_seq_clk - clock                                       |
// |            fcl_seq_rst - asynchronous active-high reset              |
// |            bus         - fcl_mac_seq_if.master (control, buffer      |
// |                          reads, MAC lanes, result handshake)         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fcl_mac_seq
  import fcl_pkg::*;
(
  input  logic          fcl_seq_clk,
  input  logic          fcl_seq_rst,
  fcl_mac_seq_if.master bus
);

  fcl_seq_state_e        r_state, w_state_nxt;
  logic                  w_busy, w_rd_en;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [LEN_WIDTH:0]    w_pairs;
  logic [ADDR_WIDTH-1:0] r_addr, r_last_addr;
  logic                  r_odd, r_v1, r_v2, r_tail1;
  acc_t                  r_acc, r_bias, r_res_data;
  logic                  r_sat, r_res_valid, r_res_sat;
  acc_t                  w_mac_ext, w_acc_sum, w_bias_sum;
  logic                  w_acc_ovf, w_bias_ovf;
  pair_t                 w_pair_a, w_pair_b;

  // Oversized lengths are clamped rather than rejected.
  assign w_len   = (bus.in_len_i > LEN_WIDTH'(MAX_INPUTS)) ? LEN_WIDTH'(MAX_INPUTS)
                                                           : bus.in_len_i;
  assign w_pairs = ({1'b0, w_len} + (LEN_WIDTH+1)'(1)) >> 1;

  assign w_mac_ext = {{(ACC_WIDTH-MAC_WIDTH){1'b0}}, bus.mac_sum_i};

  fcl_sat_add u_acc_add (
    .a   (r_acc),
    .b   (w_mac_ext),
    .sum (w_acc_sum),
    .ovf (w_acc_ovf)
  );

  fcl_sat_add u_bias_add (
    .a   (r_acc),
    .b   (r_bias),
    .sum (w_bias_sum),
    .ovf (w_bias_ovf)
  );

  always_ff @(posedge fcl_seq_clk or posedge fcl_seq_rst) begin
    if (fcl_seq_rst) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != ST_IDLE);
    w_rd_en     = (r_state == ST_RUN);
    case (r_state)
      ST_IDLE:  if (bus.start_i) w_state_nxt = (w_len == '0) ? ST_OUT : ST_RUN;
      ST_RUN:   if (r_addr == r_last_addr) w_state_nxt = ST_DRAIN;
      // No read is issued in DRAIN, so once v1 is low the pipe is empty
      // after this edge; the final v2 accumulate lands on the same edge,
      // leaving acc complete for OUT.
      ST_DRAIN: if (!r_v1) w_state_nxt = ST_OUT;
      ST_OUT:   w_state_nxt = ST_HOLD;
      ST_HOLD:  if (bus.res_ready_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fcl_seq_clk or posedge fcl_seq_rst) begin
    if (fcl_seq_rst) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_odd       <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_tail1     <= 1'b0;
      r_acc       <= '0;
      r_bias      <= '0;
      r_sat       <= 1'b0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_res_sat   <= 1'b0;
    end else begin
      r_v1    <= w_rd_en;
      r_v2    <= r_v1;
      // Marks the half-empty final pair of an odd-length neuron.
      r_tail1 <= w_rd_en && (r_addr == r_last_addr) && r_odd;

      // The MAC output register free-runs; only v2 qualifies its value.
      if (r_v2) begin
        r_acc <= w_acc_sum;
        r_sat <= r_sat | w_acc_ovf;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_addr      <= '0;
            r_last_addr <= ADDR_WIDTH'(w_pairs - (LEN_WIDTH+1)'(1));
            r_odd       <= w_len[0];
            r_bias      <= bus.bias_i;
            r_acc       <= '0;
            r_sat       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_addr != r_last_addr) r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        ST_OUT: begin
          r_res_data  <= w_bias_sum;
          r_res_sat   <= r_sat | w_bias_ovf;
          r_res_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (bus.res_ready_i) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pair_a = '0;
    w_pair_b = '0;
    if (r_v1) begin
      w_pair_a[1] = bus.wgt_rd_data_i[0];
      w_pair_a[0] = bus.act_rd_data_i[0];
      if (!r_tail1) begin
        w_pair_b[1] = bus.wgt_rd_data_i[1];
        w_pair_b[0] = bus.act_rd_data_i[1];
      end
    end
  end

  assign bus.busy_o       = w_busy;
  assign bus.rd_en_o      = w_rd_en;
  assign bus.rd_addr_o    = r_addr;
  assign bus.mac_pair_a_o = w_pair_a;
  assign bus.mac_pair_b_o = w_pair_b;
  assign bus.res_valid_o  = r_res_valid;
  assign bus.res_data_o   = r_res_data;
  assign bus.res_sat_o    = r_res_sat;

endmodule
`default_nettype wire

// File: tb/tb_fcl_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fcl_mac_seq                                            |
// | Purpose  : Directed self-checking bench for fcl_mac_seq with a       |
// |            layer-buffer model and a registered two-lane MAC model.   |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fcl_mac_seq;
  import fcl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  operand_t act_mem [0:MAX_INPUTS-1];
  operand_t wgt_mem [0:MAX_INPUTS-1];

  fcl_mac_seq_if bus ();

  fcl_mac_seq dut (
    .fcl_seq_clk (clk),
    .fcl_seq_rst (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Layer buffers: one-cycle read latency, two elements per pair address.
  always @(posedge clk) begin
    if (bus.rd_en_o) begin
      for (int e = 0; e < 2; e++) begin
        int idx;
        idx = 2*int'(bus.rd_addr_o) + e;
        bus.act_rd_data_i[e] <= (idx < MAX_INPUTS) ? act_mem[idx] : 8'hEE;
        bus.wgt_rd_data_i[e] <= (idx < MAX_INPUTS) ? wgt_mem[idx] : 8'hEE;
      end
    end
  end

  // MAC unit: registered, no enable, no reset.
  always @(posedge clk) begin
    bus.mac_sum_i <= MAC_WIDTH'(bus.mac_pair_a_o[0]) * MAC_WIDTH'(bus.mac_pair_a_o[1])
                   + MAC_WIDTH'(bus.mac_pair_b_o[0]) * MAC_WIDTH'(bus.mac_pair_b_o[1]);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input int a_val, input int w_val);
    for (int i = 0; i < MAX_INPUTS; i++) begin
      act_mem[i] = (i < n) ? operand_t'(a_val) : 8'd0;
      wgt_mem[i] = (i < n) ? operand_t'(w_val) : 8'd0;
    end
  endtask

  // Drives start during cycle 0; returns at the sample point of cycle 1.
  task automatic start_neuron(input int len, input int bias);
    bus.start_i  = 1'b1;
    bus.in_len_i = LEN_WIDTH'(len);
    bus.bias_i   = acc_t'(bias);
    tick();
    bus.start_i  = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    cyc = 1;
    while (bus.res_valid_o !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy_o), 0);
    chk({tag, "_rden"},  32'(bus.rd_en_o), 0);
    chk({tag, "_addr"},  32'(bus.rd_addr_o), 0);
    chk({tag, "_pa"},    32'(bus.mac_pair_a_o), 0);
    chk({tag, "_pb"},    32'(bus.mac_pair_b_o), 0);
    chk({tag, "_valid"}, 32'(bus.res_valid_o), 0);
    chk({tag, "_data"},  32'(bus.res_data_o), 0);
    chk({tag, "_sat"},   32'(bus.res_sat_o), 0);
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.in_len_i    = '0;
    bus.bias_i      = '0;
    bus.res_ready_i = 1'b1;
    fill(0, 0, 0);

    // Reset state
    tick(); tick();
    chk_all_zero("rst");
    rst = 1'b0;
    tick();

    // L=4: 1*5+2*6+3*7+4*8+10 = 80
    fill(0, 0, 0);
    act_mem[0] = 1; act_mem[1] = 2; act_mem[2] = 3; act_mem[3] = 4;
    wgt_mem[0] = 5; wgt_mem[1] = 6; wgt_mem[2] = 7; wgt_mem[3] = 8;
    start_neuron(4, 10);
    chk("l4_c1_rden", 32'(bus.rd_en_o), 1);
    chk("l4_c1_addr", 32'(bus.rd_addr_o), 0);
    chk("l4_c1_busy", 32'(bus.busy_o), 1);
    tick();
    chk("l4_c2_rden", 32'(bus.rd_en_o), 1);
    chk("l4_c2_addr", 32'(bus.rd_addr_o), 1);
    chk("l4_c2_pa", 32'(bus.mac_pair_a_o), 32'h0501);
    chk("l4_c2_pb", 32'(bus.mac_pair_b_o), 32'h0602);
    tick();
    chk("l4_c3_rden", 32'(bus.rd_en_o), 0);
    chk("l4_c3_pa", 32'(bus.mac_pair_a_o), 32'h0703);
    chk("l4_c3_pb", 32'(bus.mac_pair_b_o), 32'h0804);
    tick();
    chk("l4_c4_pa", 32'(bus.mac_pair_a_o), 0);
    tick();
    chk("l4_c5_valid", 32'(bus.res_valid_o), 0);
    tick();
    chk("l4_c6_valid", 32'(bus.res_valid_o), 1);
    chk("l4_data", 32'(bus.res_data_o), 80);
    chk("l4_sat", 32'(bus.res_sat_o), 0);
    tick();
    chk("l4_c7_valid", 32'(bus.res_valid_o), 0);
    chk("l4_c7_busy", 32'(bus.busy_o), 0);

    // L=3: element 3 holds junk that must not reach lane b; 5+12+21 = 38
    act_mem[3] = 99; wgt_mem[3] = 99;
    start_neuron(3, 0);
    tick(); tick();
    chk("l3_last_pa", 32'(bus.mac_pair_a_o), 32'h0703);
    chk("l3_last_pb", 32'(bus.mac_pair_b_o), 0);
    tick(); tick(); tick();
    chk("l3_valid", 32'(bus.res_valid_o), 1);
    chk("l3_data", 32'(bus.res_data_o), 38);
    chk("l3_sat", 32'(bus.res_sat_o), 0);
    tick();

    // L=400 all 255: 26,010,000 saturates; valid at P+4 = 204
    fill(400, 255, 255);
    start_neuron(400, 0);
    wait_valid(400);
    chk("l400_lat", 32'(cyc), 204);
    chk("l400_data", 32'(bus.res_data_o), 32'hFFFFFF);
    chk("l400_sat", 32'(bus.res_sat_o), 1);
    tick();

    // Oversized length clamps to 400 pairs-worth: same latency
    start_neuron(450, 0);
    wait_valid(400);
    chk("clamp_lat", 32'(cyc), 204);
    tick();

    // L=0, bias=7: no reads, valid in cycle 2
    start_neuron(0, 7);
    chk("l0_c1_rden", 32'(bus.rd_en_o), 0);
    chk("l0_c1_busy", 32'(bus.busy_o), 1);
    chk("l0_c1_valid", 32'(bus.res_valid_o), 0);
    tick();
    chk("l0_c2_rden", 32'(bus.rd_en_o), 0);
    chk("l0_c2_valid", 32'(bus.res_valid_o), 1);
    chk("l0_data", 32'(bus.res_data_o), 7);
    chk("l0_sat", 32'(bus.res_sat_o), 0);
    tick();

    // L=2 with back-pressure and a start pulse during HOLD: 8+15+1 = 24
    fill(0, 0, 0);
    act_mem[0] = 2; act_mem[1] = 3; wgt_mem[0] = 4; wgt_mem[1] = 5;
    bus.res_ready_i = 1'b0;
    start_neuron(2, 1);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.res_valid_o), 1);
      chk("hold_data", 32'(bus.res_data_o), 24);
      chk("hold_busy", 32'(bus.busy_o), 1);
      bus.start_i = (i == 1);
      if (i == 4) bus.res_ready_i = 1'b1;
      tick();
    end
    bus.start_i = 1'b0;
    chk("hold_done_valid", 32'(bus.res_valid_o), 0);
    chk("hold_done_busy", 32'(bus.busy_o), 0);
    tick();
    chk("hold_ignored_rden", 32'(bus.rd_en_o), 0);
    chk("hold_ignored_busy", 32'(bus.busy_o), 0);

    // Reset in RUN of an L=8 neuron, then a clean L=2 neuron
    fill(8, 200, 200);
    start_neuron(8, 5);
    tick(); tick();
    chk("abort_c3_rden", 32'(bus.rd_en_o), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("abort_rst");
    tick(); tick();
    rst = 1'b0;
    fill(2, 1, 1);
    tick();
    start_neuron(2, 0);
    tick(); tick(); tick();
    chk("post_c4_valid", 32'(bus.res_valid_o), 0);
    tick();
    chk("post_c5_valid", 32'(bus.res_valid_o), 1);
    chk("post_data", 32'(bus.res_data_o), 2);
    chk("post_sat", 32'(bus.res_sat_o), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
